// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
//   CNT_WIDTH  : width of the completed-access statistics counters
//   WAIT_WIDTH : width of the wait-state down-counter (0..15 wait states)
//   dmem_state_e : responder FSM state encoding
//   is_aligned() : true when a byte address is word aligned
package data_mem_responder_pkg;

  localparam int CNT_WIDTH  = 16;
  localparam int WAIT_WIDTH = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_ACK  = 2'd2
  } dmem_state_e;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the MEM stage (master) and the responder (slave).
//   mem_ren, mem_wen : read / write request, held while mem_stall=1
//   mem_addr         : byte address
//   mem_dout         : write data, CPU -> memory
//   mem_din          : read data, memory -> CPU, valid in the ACK cycle
//   mem_stall        : access in progress, pipeline frozen
//   mem_err          : misaligned-access pulse in the ACK cycle
interface data_mem_responder_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout,
    input  mem_din, mem_stall, mem_err
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout,
    output mem_din, mem_stall, mem_err
  );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word RAM for the data-memory responder: asynchronous read, synchronous write.
//   clk   : clock
//   we    : write enable, data written at the rising edge
//   idx   : word index shared by read and write
//   wdata : write data
//   rdata : read data at idx (combinational)
module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the pipeline data-memory interface. Serves word reads and
// writes with WAIT_CYCLES wait states, stalling the pipeline while busy.
//   clk      : clock
//   rst_n    : synchronous active-low reset (array contents retained)
//   bus      : data-memory bus, slave side
//   rd_count : completed aligned reads, saturating
//   wr_count : completed aligned writes, saturating
//
// state     | meaning
// DMEM_IDLE | no access outstanding; a new request is first seen here
// DMEM_WAIT | counting down wait states, stall held high
// DMEM_ACK  | access completes this cycle, read data / error presented
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [WAIT_WIDTH-1:0] LOAD_CNT =
    ZERO_WAIT ? '0 : WAIT_WIDTH'(WAIT_CYCLES - 1);

  dmem_state_e           state;
  logic [WAIT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0]  rd_q;
  logic [CNT_WIDTH-1:0]  wr_q;

  logic        req;
  logic        aligned;
  logic        ack;
  logic        is_read;
  logic        we;
  logic [31:0] rdata;
  logic        unused_addr;

  assign req     = bus.mem_ren | bus.mem_wen;
  assign aligned = is_aligned(bus.mem_addr);
  // A write wins when both requests are raised together.
  assign is_read = bus.mem_ren & ~bus.mem_wen;

  // With no wait states the IDLE cycle that sees the request is the ACK cycle.
  // Gating with rst_n keeps a write from committing at a reset edge.
  assign ack = rst_n & req &
               ((state == DMEM_ACK) | ((state == DMEM_IDLE) & ZERO_WAIT));
  assign we  = ack & bus.mem_wen & aligned;

  assign bus.mem_stall = rst_n & req & ~ZERO_WAIT &
                         ((state == DMEM_IDLE) | (state == DMEM_WAIT));
  assign bus.mem_din   = (ack & is_read & aligned) ? rdata : 32'h0;
  assign bus.mem_err   = ack & ~aligned;

  // Address bits above the array depth are ignored, so the index wraps.
  assign unused_addr = ^bus.mem_addr[31:ADDR_WIDTH+2];

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (bus.mem_addr[ADDR_WIDTH+1:2]),
    .wdata (bus.mem_dout),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DMEM_IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (req && !ZERO_WAIT) begin
            cnt   <= LOAD_CNT;
            state <= (LOAD_CNT == '0) ? DMEM_ACK : DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          if (!req) begin
            // Flush: the pipeline withdrew the request, nothing commits.
            state <= DMEM_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - WAIT_WIDTH'(1);
            if (cnt == WAIT_WIDTH'(1)) state <= DMEM_ACK;
          end
        end
        DMEM_ACK: state <= DMEM_IDLE;
        default:  state <= DMEM_IDLE;
      endcase

      if (ack && aligned && is_read && (rd_q != '1)) rd_q <= rd_q + 1'b1;
      if (we && (wr_q != '1))                         wr_q <= wr_q + 1'b1;
    end
  end

  assign rd_count = rd_q;
  assign wr_count = wr_q;

endmodule
